// File: rtl/packet_gen_sweep.sv
// AXI4-Stream test-packet source for DCMAC bring-up. It supports a fixed or swept packet
// length, a counter or per-segment data pattern, packet-number tagging, and sent-traffic counters.
module packet_gen_sweep #(
   parameter int DW    = 512,
   parameter int SEG_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [31:0]       packet_count,
   input  logic [15:0]       len_min,
   input  logic [15:0]       len_max,
   input  logic [15:0]       idle_cycles,
   input  logic [15:0]       initial_value,
   input  logic              data_mode,
   input  logic              len_mode,
   input  logic              tag_en,
   output logic              busy,
   output logic [31:0]       pkts_sent,
   output logic [47:0]       bytes_sent,
   output logic [DW-1:0]     axis_out_tdata,
   output logic [DW/8-1:0]   axis_out_tkeep,
   output logic              axis_out_tlast,
   output logic              axis_out_tvalid,
   input  logic              axis_out_tready
);

   localparam int DB   = DW / 8;
   localparam int NSEG = DW / SEG_W;
   localparam int WPS  = SEG_W / 16;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t state, state_next;

   logic [31:0] cfg_count;
   logic [15:0] cfg_len_lo;
   logic [15:0] cfg_len_hi;
   logic [15:0] cfg_idle;
   logic        cfg_data_mode;
   logic        cfg_tag_en;

   logic [31:0] pkt_num;
   logic [15:0] cur_len;
   logic [15:0] bytes_left;
   logic [15:0] data;
   logic [15:0] gap_cnt;
   logic        stop_seen;

   logic [15:0] len_min_eff;
   logic        sweep_ok;
   logic        fire;
   logic        last_beat;
   logic        first_beat;
   logic        run_done;
   logic [15:0] next_len;
   logic [15:0] data_inc;

   // A swept range that is empty collapses to a fixed length of len_min.
   assign len_min_eff = (len_min == 16'd0) ? 16'd1 : len_min;
   assign sweep_ok    = len_mode && (len_max >= len_min_eff);

   assign fire       = axis_out_tvalid && axis_out_tready;
   assign last_beat  = bytes_left <= 16'(DB);
   assign first_beat = bytes_left == cur_len;
   assign run_done   = ((cfg_count != 32'd0) && (pkt_num == cfg_count)) || stop_seen || stop;
   assign next_len   = (cur_len >= cfg_len_hi) ? cfg_len_lo : cur_len + 16'd1;
   assign data_inc   = cfg_data_mode ? 16'(NSEG) : 16'd1;

   assign busy = start || (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (fire && last_beat) begin
               if (run_done) begin
                  state_next = IDLE;
               end else if (cfg_idle != 16'd0) begin
                  state_next = GAP;
               end else begin
                  state_next = SEND;
               end
            end
         end
         GAP: begin
            if (stop || stop_seen) begin
               state_next = IDLE;
            end else if (gap_cnt <= 16'd1) begin
               state_next = SEND;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The gap counter is loaded with idle_cycles, so the GAP state lasts exactly that many clocks.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_count     <= '0;
         cfg_len_lo    <= 16'd1;
         cfg_len_hi    <= 16'd1;
         cfg_idle      <= '0;
         cfg_data_mode <= 1'b0;
         cfg_tag_en    <= 1'b0;
         pkt_num       <= '0;
         cur_len       <= 16'd1;
         bytes_left    <= 16'd1;
         data          <= '0;
         gap_cnt       <= '0;
         stop_seen     <= 1'b0;
         pkts_sent     <= '0;
         bytes_sent    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cfg_count     <= packet_count;
                  cfg_len_lo    <= len_min_eff;
                  cfg_len_hi    <= sweep_ok ? len_max : len_min_eff;
                  cfg_idle      <= idle_cycles;
                  cfg_data_mode <= data_mode;
                  cfg_tag_en    <= tag_en;
                  pkt_num       <= 32'd1;
                  cur_len       <= len_min_eff;
                  bytes_left    <= len_min_eff;
                  data          <= initial_value;
                  gap_cnt       <= '0;
                  stop_seen     <= 1'b0;
                  pkts_sent     <= '0;
                  bytes_sent    <= '0;
               end
            end
            SEND: begin
               if (stop) begin
                  stop_seen <= 1'b1;
               end
               if (fire) begin
                  data <= data + data_inc;
                  if (last_beat) begin
                     pkts_sent  <= pkts_sent + 32'd1;
                     bytes_sent <= bytes_sent + 48'(cur_len);
                     cur_len    <= next_len;
                     bytes_left <= next_len;
                     pkt_num    <= pkt_num + 32'd1;
                     gap_cnt    <= cfg_idle;
                  end else begin
                     bytes_left <= bytes_left - 16'(DB);
                  end
               end
            end
            GAP: begin
               if (stop) begin
                  stop_seen <= 1'b1;
               end
               gap_cnt <= gap_cnt - 16'd1;
            end
            default: begin
               stop_seen <= 1'b0;
            end
         endcase
      end
   end

   // Beat contents depend only on registered state, so they stay stable under backpressure.
   always_comb begin
      axis_out_tvalid = (state == SEND) && !reset;
      axis_out_tlast  = last_beat;
      for (int i = 0; i < DB; i++) begin
         axis_out_tkeep[i] = !last_beat || (i < int'(bytes_left));
      end
      for (int k = 0; k < NSEG; k++) begin
         for (int w = 0; w < WPS; w++) begin
            axis_out_tdata[SEG_W*k + 16*w +: 16] = cfg_data_mode ? data + 16'(k) : data;
         end
      end
      if (cfg_tag_en && first_beat) begin
         axis_out_tdata[31:0] = pkt_num;
      end
   end

endmodule

// File: tb/tb_packet_gen_sweep.sv
// Scoreboard bench for packet_gen_sweep at DW=512: stimulus queues expected beats and
// a negedge monitor checks every handshake, the inter-packet gaps and the run counters.
module tb_packet_gen_sweep;

   localparam int DW = 512;
   localparam int DB = DW / 8;

   logic              clk;
   logic              reset;
   logic              start;
   logic              stop;
   logic [31:0]       packet_count;
   logic [15:0]       len_min;
   logic [15:0]       len_max;
   logic [15:0]       idle_cycles;
   logic [15:0]       initial_value;
   logic              data_mode;
   logic              len_mode;
   logic              tag_en;
   logic              busy;
   logic [31:0]       pkts_sent;
   logic [47:0]       bytes_sent;
   logic [DW-1:0]     tdata;
   logic [DB-1:0]     tkeep;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [DB-1:0] k;
      logic          l;
   } beat_t;

   beat_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int pkts_seen = 0;
   int beats_seen = 0;
   int gap_exp = 0;
   int gap_cnt = 0;
   bit in_gap = 0;
   bit rand_rdy = 0;

   packet_gen_sweep #(.DW(DW), .SEG_W(128)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .stop            (stop),
      .packet_count    (packet_count),
      .len_min         (len_min),
      .len_max         (len_max),
      .idle_cycles     (idle_cycles),
      .initial_value   (initial_value),
      .data_mode       (data_mode),
      .len_mode        (len_mode),
      .tag_en          (tag_en),
      .busy            (busy),
      .pkts_sent       (pkts_sent),
      .bytes_sent      (bytes_sent),
      .axis_out_tdata  (tdata),
      .axis_out_tkeep  (tkeep),
      .axis_out_tlast  (tlast),
      .axis_out_tvalid (tvalid),
      .axis_out_tready (tready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops one expected beat per handshake and measures tvalid-low runs between packets.
   always @(negedge clk) begin
      if (!reset) begin
         if (!busy) in_gap = 0;
         if (tvalid) begin
            if (in_gap) begin
               checkOutput("gap_len", DW'(gap_cnt), DW'(gap_exp));
               in_gap = 0;
            end
         end else if (in_gap) begin
            gap_cnt++;
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_beat", DW'(1), DW'(0));
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               checkOutput("beat_tdata", tdata, b.d);
               checkOutput("beat_tkeep", DW'(tkeep), DW'(b.k));
               checkOutput("beat_tlast", DW'(tlast), DW'(b.l));
            end
            beats_seen++;
            if (tlast) begin
               pkts_seen++;
               in_gap = 1;
               gap_cnt = 0;
            end
         end
      end
   end

   task automatic pushModel(input logic [15:0] init, input logic mode, input logic tag,
                            input logic lmode, input int lmin, input int lmax, input int npk);
      int lo, hi, len, nb, rem;
      logic [15:0] d;
      beat_t b;
      lo = (lmin < 1) ? 1 : lmin;
      hi = (lmode && lmax >= lo) ? lmax : lo;
      len = lo;
      d = init;
      for (int p = 1; p <= npk; p++) begin
         nb = (len + DB - 1) / DB;
         rem = len % DB;
         for (int bt = 0; bt < nb; bt++) begin
            for (int w = 0; w < DW / 16; w++) begin
               b.d[16*w +: 16] = mode ? d + 16'(w / 8) : d;
            end
            if (tag && bt == 0) b.d[31:0] = 32'(p);
            b.l = (bt == nb - 1);
            b.k = (b.l && rem != 0) ? (64'd1 << rem) - 64'd1 : '1;
            exp_q.push_back(b);
            d = d + (mode ? 16'd4 : 16'd1);
         end
         len = (len >= hi) ? lo : len + 1;
      end
   endtask

   task automatic applyStimulus(input logic [15:0] init, input logic dmode, input logic lmode,
                                input logic tag, input logic [15:0] lmin, input logic [15:0] lmax,
                                input logic [31:0] cnt, input logic [15:0] idle);
      @(posedge clk);
      #2;
      initial_value = init;
      data_mode = dmode;
      len_mode = lmode;
      tag_en = tag;
      len_min = lmin;
      len_max = lmax;
      packet_count = cnt;
      idle_cycles = idle;
      gap_exp = int'(idle);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while (n < limit) begin
         @(negedge clk);
         #1;
         if (!busy && exp_q.size() == 0) break;
         n++;
      end
      if (n >= limit) checkOutput("run_timeout", DW'(1), DW'(0));
      checkOutput("queue_drained", DW'(exp_q.size()), DW'(0));
   endtask

   task automatic waitCount(input string name, input int target, input bit use_beats);
      int n;
      n = 0;
      while (((use_beats ? beats_seen : pkts_seen) < target) && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 2000) checkOutput(name, DW'(1), DW'(0));
   endtask

   task automatic checkRun(input int pk, input int by);
      checkOutput("pkts_sent", DW'(pkts_sent), DW'(pk));
      checkOutput("bytes_sent", DW'(bytes_sent), DW'(by));
   endtask

   initial begin
      beat_t b;
      int base;
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      packet_count = '0;
      len_min = '0;
      len_max = '0;
      idle_cycles = '0;
      initial_value = '0;
      data_mode = 1'b0;
      len_mode = 1'b0;
      tag_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_tvalid", DW'(tvalid), DW'(0));
      checkOutput("reset_busy", DW'(busy), DW'(0));
      checkRun(0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Two 100-byte counter packets back to back.
      b.k = '1; b.l = 0; b.d = {32{16'h0010}}; exp_q.push_back(b);
      b.k = 64'h0000000FFFFFFFFF; b.l = 1; b.d = {32{16'h0011}}; exp_q.push_back(b);
      b.k = '1; b.l = 0; b.d = {32{16'h0012}}; exp_q.push_back(b);
      b.k = 64'h0000000FFFFFFFFF; b.l = 1; b.d = {32{16'h0013}}; exp_q.push_back(b);
      applyStimulus(16'h0010, 0, 0, 0, 16'd100, 16'd0, 32'd2, 16'd0);
      waitIdle(200);
      checkRun(2, 200);

      // Per-segment pattern with packet-number tag.
      b.k = '1; b.l = 0;
      b.d = {{8{16'd8}}, {8{16'd7}}, {8{16'd6}}, {8{16'd5}}};
      b.d[31:0] = 32'h0000_0001;
      exp_q.push_back(b);
      b.l = 1;
      b.d = {{8{16'd12}}, {8{16'd11}}, {8{16'd10}}, {8{16'd9}}};
      exp_q.push_back(b);
      applyStimulus(16'd5, 1, 0, 1, 16'd128, 16'd0, 32'd1, 16'd0);
      waitIdle(200);
      checkRun(1, 128);

      // Length sweep 62..65 wrapping back to 62.
      pushModel(16'h0100, 0, 0, 1, 62, 65, 5);
      applyStimulus(16'h0100, 0, 1, 0, 16'd62, 16'd65, 32'd5, 16'd0);
      waitIdle(300);
      checkRun(5, 316);

      // Idle gaps with random backpressure and data wrap past 0xFFFF.
      rand_rdy = 1;
      pushModel(16'hFFFE, 1, 1, 0, 150, 0, 3);
      applyStimulus(16'hFFFE, 1, 0, 1, 16'd150, 16'd0, 32'd3, 16'd3);
      waitIdle(2000);
      checkRun(3, 450);
      rand_rdy = 0;

      // Continuous run stopped during the first beat of packet 3.
      pushModel(16'h0000, 0, 0, 0, 256, 0, 3);
      base = pkts_seen;
      applyStimulus(16'h0000, 0, 0, 0, 16'd256, 16'd0, 32'd0, 16'd0);
      waitCount("wait_pkt2", base + 2, 0);
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      waitCount("wait_pkt3", base + 3, 0);
      @(negedge clk);
      checkOutput("busy_after_stop", DW'(busy), DW'(0));
      waitIdle(200);
      checkRun(3, 768);

      // Stop during a gap ends the run without another packet.
      pushModel(16'h0040, 0, 0, 0, 64, 0, 1);
      base = pkts_seen;
      applyStimulus(16'h0040, 0, 0, 0, 16'd64, 16'd0, 32'd0, 16'd20);
      waitCount("wait_gap_pkt", base + 1, 0);
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      waitIdle(200);
      checkRun(1, 64);

      // Reset mid-packet, then restart from initial_value.
      pushModel(16'h0200, 0, 0, 0, 256, 0, 1);
      base = beats_seen;
      applyStimulus(16'h0200, 0, 0, 0, 16'd256, 16'd0, 32'd1, 16'd0);
      waitCount("wait_beat2", base + 2, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("tvalid_in_reset", DW'(tvalid), DW'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checkOutput("tvalid_after_reset", DW'(tvalid), DW'(0));
      checkOutput("busy_after_reset", DW'(busy), DW'(0));
      checkRun(0, 0);
      pushModel(16'h0200, 0, 0, 0, 256, 0, 1);
      applyStimulus(16'h0200, 0, 0, 0, 16'd256, 16'd0, 32'd1, 16'd0);
      waitIdle(200);
      checkRun(1, 256);

      // Zero length becomes one byte; an inverted sweep range stays at len_min.
      b.k = 64'h1; b.l = 1; b.d = {32{16'h0300}}; exp_q.push_back(b);
      applyStimulus(16'h0300, 0, 0, 0, 16'd0, 16'd0, 32'd1, 16'd0);
      waitIdle(100);
      checkRun(1, 1);
      pushModel(16'h0400, 0, 0, 1, 10, 5, 2);
      applyStimulus(16'h0400, 0, 1, 0, 16'd10, 16'd5, 32'd2, 16'd2);
      waitIdle(100);
      checkRun(2, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/packet_gen_sweep.md
Name: packet_gen_sweep

Overview:
- Next-generation AXI4-Stream test-packet source for DCMAC bring-up.
- Width is parametrised to any multiple of 128 bits, so it serves 1 to 8 DCMAC segments.
- Adds run-time data-pattern selection, packet-length sweep mode, optional packet-number tagging, continuous mode, graceful stop and sent-traffic counters.
- Sits between the control-register block and the DCMAC TX stream (or a TX FIFO).

Parameters:
DW, 512, stream width in bits; multiple of 128, range 128..1024
SEG_W, 128, DCMAC segment width in bits; fixed

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
stop  in  1  finish current packet, then go IDLE
packet_count  in  32  packets per run; 0 = run until stop
len_min  in  16  packet length in bytes (fixed mode) or sweep low bound
len_max  in  16  sweep high bound
idle_cycles  in  16  dead clocks between packets
initial_value  in  16  first data value
data_mode  in  1  0 = 16-bit counter replicated; 1 = per-segment number
len_mode  in  1  0 = fixed len_min; 1 = sweep len_min..len_max
tag_en  in  1  overwrite bytes 0-3 of each first beat with the packet number
busy  out  1  start OR state != IDLE
pkts_sent  out  32  packets completed in this run
bytes_sent  out  48  bytes completed in this run
axis_out_tdata  out  DW  data
axis_out_tkeep  out  DW/8  byte enables
axis_out_tlast  out  1  last beat
axis_out_tvalid  out  1  valid
axis_out_tready  in  1  ready

Behaviour:
- DB = DW/8, NSEG = DW/128.
- Reset values: state IDLE, tvalid 0, pkts_sent 0, bytes_sent 0. tvalid is also forced 0 combinationally while reset is high.
- Reset mid-packet abandons the packet; no tlast is emitted.
- States:
  - IDLE: on start, latch all config inputs, clear counters, pkt_num = 1, cur_len = effective len_min, data = initial_value. Go to SEND; tvalid rises the next cycle.
  - SEND: tvalid = 1.
  - GAP: count down idle_cycles; then SEND.
- Config inputs are ignored outside IDLE.
- Effective length = max(len, 1). In sweep mode with len_max < len_min, use len_min as a fixed length.
- Beats per packet = ceil(len/DB). tlast on the final beat.
- tkeep is all ones, except on the tlast beat when len mod DB != 0: tkeep = (1 << (len mod DB)) - 1.
- Data pattern:
  - mode 0: each 16-bit word = data; data increments by 1 per accepted beat.
  - mode 1: segment k (bits 128k+127:128k) carries data+k replicated 8 times; data increments by NSEG per accepted beat.
  - All arithmetic is mod 2^16.
  - The data value continues across packets and is never reset between packets.
- Tag: when tag_en = 1, tdata[31:0] of the first beat = pkt_num (1-based). Other bytes keep the pattern.
- Handshake:
  - tdata, tkeep and tlast are stable while tvalid = 1 and tready = 0.
  - Advance only on tvalid & tready.
- On the tlast handshake:
  - pkts_sent += 1; bytes_sent += len.
  - Sweep mode: next len = len + 1, wrapping to len_min after len_max.
  - If pkt_num == packet_count (count != 0), or stop was seen: go to IDLE.
  - Otherwise pkt_num += 1; go to GAP if idle_cycles != 0, else SEND with no bubble.
- tvalid is low for exactly idle_cycles clocks between packets.
- stop is sticky once seen in SEND or GAP. It never truncates a packet.
- stop seen in GAP: go to IDLE immediately with no further packets.
- stop in IDLE is ignored.
- start in SEND or GAP is ignored.
- pkts_sent and bytes_sent hold their values in IDLE until the next start.

Test Plan:
- DW=512, mode 0, len_min=100, count=2, idle=0, init=0x0010 -> 4 beats, words 0x0010..0x0013; beats 2 and 4 have tlast and tkeep = 0x0000000FFFFFFFFF; no gap between packets; pkts_sent=2, bytes_sent=200.
- DW=512, mode 1, init=5, len=128 -> beat 1 segments = 5,6,7,8; beat 2 = 9,10,11,12; tag_en=1 -> beat 1 tdata[31:0] = 0x00000001.
- Sweep len 62..65, count=5, DW=512 -> lengths 62,63,64,65,62:
  - 64-byte packet: 1 beat, tkeep all ones.
  - 65-byte packet: 2 beats, last tkeep = 0x1.
  - bytes_sent = 316.
- idle_cycles=3, random tready with ~50% duty -> tvalid low for exactly 3 clocks after each tlast handshake; tdata held stable under backpressure; no beats lost or duplicated.
- count=0, stop pulsed during beat 1 of packet 3 (len=256, DW=512) -> packet 3 completes all 4 beats; busy falls the cycle after; pkts_sent=3.
- reset held 1 cycle mid-packet -> tvalid=0 that cycle and after, counters 0, state IDLE; a new start restarts from initial_value.
